// File: rtl/capture_seq.sv
// Command-driven capture sequencer: arm/force capture, pack samples into a byte buffer, dump over valid/ready.
// Optional dump header (0xA5, depth byte) is built when CAPTURE_HEADER_EN is defined.
module capture_seq #(
  parameter int ADDR_W     = 6,
  parameter int SAMPLE_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       armed,
  output logic       done
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_TRIG = (SAMPLE_DIV > 1) ? DIV_W'(1) : DIV_W'(0);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_CAPTURE, S_FULL, S_DUMP} state_t;
  typedef enum logic [1:0] {P_FETCH, P_LOAD, P_SEND} phase_t;

  state_t            state_q, state_d;
  phase_t            phase_q, phase_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [6:0]        sh_q, sh_d;
  logic [2:0]        bcnt_q, bcnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              sig_prev_q;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d, armed_q, armed_d, done_q, done_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        rd_q;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic              is_a, is_f, is_d, is_r, trig;
  logic              hdr_pend;
  logic [7:0]        hdr_byte;

  assign is_a = cmd_valid && (cmd_data == 8'h41);
  assign is_f = cmd_valid && (cmd_data == 8'h46);
  assign is_d = cmd_valid && (cmd_data == 8'h44);
  assign is_r = cmd_valid && (cmd_data == 8'h52);
  assign trig = sig && !sig_prev_q;

`ifdef CAPTURE_HEADER_EN
  localparam logic [8:0] DEPTH_B = 9'(DEPTH);
  logic [1:0] hdr_q, hdr_d;

  // Header index counts 0,1 then parks at 2; cleared whenever not dumping.
  always_comb begin
    hdr_d = hdr_q;
    if (state_q != S_DUMP)
      hdr_d = 2'd0;
    else if (phase_q == P_SEND && tx_ready && hdr_q != 2'd2)
      hdr_d = hdr_q + 2'd1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) hdr_q <= 2'd0;
    else     hdr_q <= hdr_d;

  assign hdr_pend = (hdr_q != 2'd2);
  assign hdr_byte = (hdr_q == 2'd0) ? 8'hA5 : DEPTH_B[7:0];
`else
  assign hdr_pend = 1'b0;
  assign hdr_byte = 8'h00;
`endif

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    sh_d       = sh_q;
    bcnt_d     = bcnt_q;
    div_d      = div_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    mem_we     = 1'b0;
    mem_wdata  = {sh_q, sig};

    case (state_q)
      S_IDLE, S_FULL: begin
        if (is_a || is_f) begin
          state_d = is_a ? S_ARMED : S_CAPTURE;
          wptr_d  = '0;
          sh_d    = '0;
          bcnt_d  = '0;
          div_d   = '0;
        end else if (is_d && state_q == S_FULL) begin
          state_d = S_DUMP;
          phase_d = P_FETCH;
          rptr_d  = '0;
        end
      end
      S_ARMED: begin
        // Trigger cycle is sample 0, so the divider is already one step along.
        if (trig) begin
          state_d = S_CAPTURE;
          sh_d    = {sh_q[5:0], 1'b1};
          bcnt_d  = 3'd1;
          div_d   = DIV_TRIG;
        end
      end
      S_CAPTURE: begin
        div_d = (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);
        if (div_q == '0) begin
          sh_d   = {sh_q[5:0], sig};
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            mem_we = 1'b1;
            wptr_d = wptr_q + 1'b1;
            if (wptr_q == {ADDR_W{1'b1}}) state_d = S_FULL;
          end
        end
      end
      S_DUMP: begin
        case (phase_q)
          P_FETCH: phase_d = P_LOAD;
          P_LOAD: begin
            tx_data_d  = hdr_pend ? hdr_byte : rd_q;
            tx_valid_d = 1'b1;
            phase_d    = P_SEND;
          end
          default: begin
            if (tx_ready) begin
              tx_valid_d = 1'b0;
              phase_d    = P_FETCH;
              if (!hdr_pend) begin
                rptr_d = rptr_q + 1'b1;
                if (rptr_q == {ADDR_W{1'b1}}) state_d = S_FULL;
              end
            end
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase

    // Reset command overrides everything, including a same-cycle final write.
    if (is_r) begin
      state_d    = S_IDLE;
      phase_d    = P_FETCH;
      wptr_d     = '0;
      rptr_d     = '0;
      sh_d       = '0;
      bcnt_d     = '0;
      div_d      = '0;
      tx_valid_d = 1'b0;
      mem_we     = 1'b0;
    end

    busy_d  = (state_d == S_ARMED) || (state_d == S_CAPTURE) || (state_d == S_DUMP);
    armed_d = (state_d == S_ARMED);
    done_d  = (state_d == S_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_q    <= P_FETCH;
      wptr_q     <= '0;
      rptr_q     <= '0;
      sh_q       <= '0;
      bcnt_q     <= '0;
      div_q      <= '0;
      sig_prev_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      armed_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      sh_q       <= sh_d;
      bcnt_q     <= bcnt_d;
      div_q      <= div_d;
      sig_prev_q <= sig;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      armed_q    <= armed_d;
      done_q     <= done_d;
    end
  end

  // Buffer RAM with registered read port.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wptr_q] <= mem_wdata;
    rd_q <= mem_q[rptr_q];
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign armed    = armed_q;
  assign done     = done_q;
endmodule

// File: tb/tb_capture_seq.sv
// Directed bench for capture_seq: ADDR_W=2 with SAMPLE_DIV=1 (u0) and SAMPLE_DIV=2 (u1).
module tb_capture_seq;
`ifdef CAPTURE_HEADER_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif
  localparam int NB = 4 + HDR;

  logic       clk = 1'b0, rst = 1'b1;
  logic       sig = 1'b0, cmd_valid = 1'b0, tx_ready = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic [7:0] tx_data;
  logic       tx_valid, busy, armed, done;
  logic       sig2 = 1'b0, cmd_valid2 = 1'b0, tx_ready2 = 1'b0;
  logic [7:0] cmd_data2 = 8'h00;
  logic [7:0] tx_data2;
  logic       tx_valid2, busy2, armed2, done2;

  int         total = 0, bad = 0;
  logic [7:0] rx [8];
  int         rx_n;
  logic       unstable;
  logic [7:0] first_b;

  capture_seq #(.ADDR_W(2), .SAMPLE_DIV(1)) u0 (
    .clk(clk), .rst(rst), .sig(sig), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .armed(armed), .done(done));

  capture_seq #(.ADDR_W(2), .SAMPLE_DIV(2)) u1 (
    .clk(clk), .rst(rst), .sig(sig2), .cmd_data(cmd_data2), .cmd_valid(cmd_valid2),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .busy(busy2), .armed(armed2), .done(done2));

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    cmd_data = c; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd_data = 8'h00;
  endtask

  task automatic send2(input logic [7:0] c);
    cmd_data2 = c; cmd_valid2 = 1'b1;
    tick();
    cmd_valid2 = 1'b0; cmd_data2 = 8'h00;
  endtask

  // Collect n bytes, counting a byte each cycle tx_valid is seen with ready held high.
  task automatic get_bytes(input int sel, input int n);
    rx_n = 0;
    for (int c = 0; c < 300 && rx_n < n; c++) begin
      if (sel == 0 ? tx_valid : tx_valid2) begin
        rx[rx_n] = (sel == 0) ? tx_data : tx_data2;
        rx_n++;
      end
      tick();
    end
    chk8("dump_count", 8'(rx_n), 8'(n));
  endtask

  function automatic logic [7:0] exp_b(input int i, input logic [7:0] d);
    if (i < HDR) return (i == 0) ? 8'hA5 : 8'h04;
    return d;
  endfunction

  initial begin
    #12;
    chk8("rst_tx_data", tx_data, 8'h00);
    chk1("rst_tx_valid", tx_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_armed", armed, 1'b0);
    chk1("rst_done", done, 1'b0);
    rst = 1'b0;
    tick();

    // Forced capture of constant 1
    sig = 1'b1;
    send(8'h46);
    chk1("f_busy", busy, 1'b1);
    repeat (31) tick();
    chk1("f_done_early", done, 1'b0);
    tick();
    chk1("f_done", done, 1'b1);
    chk1("f_busy_end", busy, 1'b0);

    // Dump latency and content
    tx_ready = 1'b1;
    send(8'h44);
    chk1("d_busy", busy, 1'b1);
    chk1("d_valid_t0", tx_valid, 1'b0);
    tick();
    chk1("d_valid_t1", tx_valid, 1'b0);
    tick();
    chk1("d_valid_t2", tx_valid, 1'b1);
    chk8("d_first", tx_data, exp_b(0, 8'hFF));
    get_bytes(0, NB);
    for (int i = 0; i < NB; i++) chk8("d_byte", rx[i], exp_b(i, 8'hFF));
    chk1("d_back_full", done, 1'b1);
    chk1("d_not_busy", busy, 1'b0);

    // Armed trigger on toggling signal
    sig = 1'b0;
    send(8'h41);
    chk1("a_armed", armed, 1'b1);
    chk1("a_done_clr", done, 1'b0);
    repeat (10) tick();
    chk1("a_still_armed", armed, 1'b1);
    sig = 1'b1;
    tick();
    chk1("a_trig_armed", armed, 1'b0);
    chk1("a_trig_busy", busy, 1'b1);
    for (int i = 0; i < 30; i++) begin sig = ~sig; tick(); end
    chk1("a_done_early", done, 1'b0);
    sig = ~sig;
    tick();
    chk1("a_done", done, 1'b1);

    // Backpressure dump of the 0xAA capture
    tx_ready = 1'b0;
    send(8'h44);
    tick(); tick();
    chk1("bp_valid", tx_valid, 1'b1);
    first_b = tx_data;
    chk8("bp_first", first_b, exp_b(0, 8'hAA));
    unstable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_valid !== 1'b1 || tx_data !== first_b) unstable = 1'b1;
    end
    chk1("bp_stable", unstable, 1'b0);
    tx_ready = 1'b1;
    get_bytes(0, NB);
    for (int i = 0; i < NB; i++) chk8("bp_byte", rx[i], exp_b(i, 8'hAA));
    chk1("bp_done", done, 1'b1);

    // Illegal commands
    send(8'h00);
    chk1("ill_00_done", done, 1'b1);
    chk1("ill_00_busy", busy, 1'b0);
    send(8'h52);
    chk1("r_done", done, 1'b0);
    chk1("r_busy", busy, 1'b0);
    send(8'h44);
    tick(); tick();
    chk1("ill_d_busy", busy, 1'b0);
    chk1("ill_d_valid", tx_valid, 1'b0);
    send(8'h46);
    repeat (4) tick();
    send(8'h41);
    chk1("ill_a_armed", armed, 1'b0);
    chk1("ill_a_busy", busy, 1'b1);
    repeat (26) tick();
    chk1("ill_a_done_early", done, 1'b0);
    tick();
    chk1("ill_a_done", done, 1'b1);

    // R in the same cycle as the final byte write
    send(8'h46);
    repeat (31) tick();
    chk1("rc_pre_done", done, 1'b0);
    send(8'h52);
    chk1("rc_done", done, 1'b0);
    chk1("rc_busy", busy, 1'b0);
    tick();
    chk1("rc_done_hold", done, 1'b0);

    // Asynchronous reset mid-dump
    send(8'h46);
    repeat (32) tick();
    chk1("ar_full", done, 1'b1);
    tx_ready = 1'b0;
    send(8'h44);
    tick(); tick();
    chk1("ar_valid", tx_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("ar_tx_valid", tx_valid, 1'b0);
    chk1("ar_busy", busy, 1'b0);
    chk1("ar_done", done, 1'b0);
    rst = 1'b0;
    tick();
    send(8'h44);
    tick(); tick();
    chk1("ar_d_valid", tx_valid, 1'b0);
    chk1("ar_d_busy", busy, 1'b0);

    // SAMPLE_DIV=2: samples on every other clock
    sig2 = 1'b1;
    send2(8'h46);
    repeat (4) tick();
    sig2 = 1'b0;
    repeat (58) tick();
    chk1("div2_done_early", done2, 1'b0);
    tick();
    chk1("div2_done", done2, 1'b1);
    tx_ready2 = 1'b1;
    send2(8'h44);
    tick(); tick();
    get_bytes(1, NB);
    for (int i = 0; i < NB; i++) chk8("div2_byte", rx[i], exp_b(i, (i == HDR) ? 8'hC0 : 8'h00));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/capture_seq.md
# capture_seq

Command-driven capture sequencer for the correlator front end. It takes the digitized single-bit signal `sig` (already synchronized to `clk`) and decodes command bytes from the UART receiver. On command it arms an edge trigger or starts capture immediately, packs samples into an internal byte buffer, and streams the buffer to the UART transmitter through a valid/ready handshake. It sits between the digitizer and the serial link, and replaces the free-running dump with host-controlled acquisition.

## Interface
- `ADDR_W`, default 6: buffer holds 2^ADDR_W bytes (8·2^ADDR_W samples). Legal range 1..8.
- `SAMPLE_DIV`, default 1: one sample every SAMPLE_DIV clocks. Must be ≥1.
- `clk` in 1: single system clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `sig` in 1: digitized signal, synchronous to `clk`.
- `cmd_data` in 8: received command byte.
- `cmd_valid` in 1: one-cycle strobe qualifying `cmd_data`.
- `tx_data` out 8: byte to transmitter.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: transmitter accepts the byte when `tx_valid & tx_ready`.
- `busy` out 1: high in ARMED, CAPTURE or DUMP.
- `armed` out 1: high in ARMED.
- `done` out 1: high in FULL (buffer holds a complete capture).

## Operation
- States: IDLE, ARMED, CAPTURE, FULL, DUMP. Reset enters IDLE.
- Commands are accepted only on a `cmd_valid` cycle. Any other byte, or a command that is illegal in the current state, is ignored with no side effect.
  - 'A' (0x41), legal in IDLE/FULL: go to ARMED.
  - 'F' (0x46), legal in IDLE/FULL: go to CAPTURE immediately.
  - 'D' (0x44), legal in FULL only: go to DUMP.
  - 'R' (0x52), legal in any state: go to IDLE and clear the write pointer and shift register. Buffer contents remain but are treated as invalid.
- ARMED: wait for a rising edge, i.e. `sig`=1 while the previous-cycle `sig` was 0. The trigger cycle is sample 0, so that sample is always 1. The state moves to CAPTURE.
- CAPTURE: a modulo-SAMPLE_DIV counter runs. A sample is taken when the counter is 0.
  - Entry via 'F': counter starts at 0.
  - Entry via trigger: counter starts at 1 mod SAMPLE_DIV.
- Packing: the first sample of each byte goes to bit 7 and the eighth to bit 0. A byte is written at the address of the 8th sample. After byte 2^ADDR_W−1 is written, the state moves to FULL.
- DUMP: bytes are sent from address 0 upward. `tx_data`/`tx_valid` hold steady until `tx_ready`. After the last handshake the state returns to FULL, so the buffer can be re-dumped.
- 'R' during DUMP: `tx_valid` drops on the next edge even if no handshake occurred. This is the only permitted early withdrawal.
- A command arriving in the same cycle as a trigger or the final byte write: the command is evaluated against the pre-edge state. 'R' wins over every other transition.

## Timing
- Reset values: `tx_data`=0x00, `tx_valid`=0, `busy`=0, `armed`=0, `done`=0. Write pointer, read pointer, shift register and divider counter are all 0.
- All outputs are registered.
- 'F' strobe at edge t: CAPTURE from t+1, first sample at edge t+1. With SAMPLE_DIV=1, the last sample is at edge t+8·2^ADDR_W and `done`=1 after that edge.
- Trigger at edge t: samples at t, t+SAMPLE_DIV, and so on.
- 'D' strobe at edge t: DUMP from t+1, first `tx_valid`=1 after edge t+2 (one-cycle buffer read latency).
- Byte gap: at least one idle cycle between a handshake and the next `tx_valid`.
- `busy`, `armed` and `done` change on the same edge as the state.

## Configuration
- `CAPTURE_HEADER_EN` defined: each dump is prefixed with 0xA5, then the byte (2^ADDR_W mod 256), then the data bytes. The prefix bytes use the same handshake.
- `CAPTURE_HEADER_EN` undefined: the dump is data bytes only, and the first `tx_data` is buffer byte 0.

## Test plan
- Reset mid-DUMP, ADDR_W=2: assert `rst` asynchronously → `tx_valid`=0, `busy`=0, `done`=0 immediately without a clock edge. A following 'D' is ignored because the state is IDLE.
- ADDR_W=2, SAMPLE_DIV=1, `sig`=1 constant, 'F' at t → `done` high after edge t+32. 'D' with `tx_ready`=1 → bytes 0xFF,0xFF,0xFF,0xFF; the state returns to FULL.
- 'A' with `sig`=0 for 10 cycles, then `sig` toggling every clock starting with 1 → capture holds 0xAA in every byte, and `armed` is high only while waiting for the trigger.
- SAMPLE_DIV=2, `sig`=1 for 4 clocks then 0, 'F' → byte 0 = 0xC0.
- Backpressure: `tx_ready` held low for 20 cycles during DUMP → `tx_data` and `tx_valid` stable throughout, and no byte is skipped or duplicated.
- Illegal and contested commands: 'D' in IDLE, 'A' in CAPTURE and 0x00 in FULL → no state change. 'R' in the same cycle as the final byte write → IDLE with `done`=0. With `CAPTURE_HEADER_EN`, ADDR_W=2 → dump starts 0xA5, 0x04.
